// File: rtl/wb_collector.sv
// Writeback collector: per-source result FIFOs funnelled onto the scoreboard
// write ports by a round-robin arbiter with valid/ready handshake.
package wb_collector_pkg;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;
endpackage

module wb_collector
    import wb_collector_pkg::exception_t;
#(
    parameter int unsigned NR_SRC        = 4,
    parameter int unsigned NR_WB         = 2,
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned TRANS_ID_BITS = wb_collector_pkg::TRANS_ID_BITS
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NR_SRC-1:0]                    src_valid_i,
    input  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0] src_trans_id_i,
    input  logic [NR_SRC-1:0][63:0]              src_result_i,
    input  exception_t [NR_SRC-1:0]              src_ex_i,
    output logic [NR_SRC-1:0]                    src_almost_full_o,
    output logic [NR_WB-1:0]                     wb_valid_o,
    output logic [NR_WB-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o,
    output logic [NR_WB-1:0][63:0]               wb_result_o,
    output exception_t [NR_WB-1:0]               wb_ex_o,
    input  logic [NR_WB-1:0]                     wb_ready_i,
    output logic                                 overflow_o
);

    localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [TRANS_ID_BITS-1:0] mem_tid [NR_SRC][DEPTH];
    logic [63:0]              mem_res [NR_SRC][DEPTH];
    exception_t               mem_ex  [NR_SRC][DEPTH];
    logic [PTR_W-1:0]         rptr    [NR_SRC];
    logic [PTR_W-1:0]         wptr    [NR_SRC];
    logic [CNT_W-1:0]         count   [NR_SRC];
    logic [SRC_W-1:0]         rr;

    logic [NR_SRC-1:0]        nonempty;
    logic [NR_SRC-1:0]        full;
    logic [NR_SRC-1:0]        pop;
    logic [NR_SRC-1:0]        push_acc;
    logic [NR_SRC-1:0]        drop;
    logic [NR_WB-1:0]         grant_valid;
    logic [SRC_W-1:0]         grant_src [NR_WB];
    logic [SRC_W-1:0]         scan;
    int unsigned              rank;
    logic                     any_pop;
    logic [SRC_W-1:0]         last_src;
    logic [SRC_W-1:0]         rr_next;

    // FIFO occupancy flags from the registered counts
    always_comb begin
        nonempty          = '0;
        full              = '0;
        src_almost_full_o = '0;
        for (int s = 0; s < NR_SRC; s++) begin
            nonempty[s]          = (count[s] != '0);
            full[s]              = (count[s] == CNT_W'(DEPTH));
            src_almost_full_o[s] = (count[s] >= CNT_W'(DEPTH - 1));
        end
    end

    // Port p takes the p-th non-empty source in scan order rr, rr+1, ...
    always_comb begin
        grant_valid = '0;
        scan        = '0;
        rank        = 0;
        for (int p = 0; p < NR_WB; p++) begin
            grant_src[p] = '0;
        end
        for (int k = 0; k < NR_SRC; k++) begin
            scan = SRC_W'((32'(rr) + 32'(k)) % NR_SRC);
            if (nonempty[scan]) begin
                for (int p = 0; p < NR_WB; p++) begin
                    if (rank == p) begin
                        grant_valid[p] = 1'b1;
                        grant_src[p]   = scan;
                    end
                end
                rank = rank + 1;
            end
        end
    end

    // Handshake: pops, and the source on the highest accepting port sets rr
    always_comb begin
        pop      = '0;
        any_pop  = 1'b0;
        last_src = '0;
        for (int p = 0; p < NR_WB; p++) begin
            if (grant_valid[p] && wb_ready_i[p]) begin
                pop[grant_src[p]] = 1'b1;
                any_pop           = 1'b1;
                last_src          = grant_src[p];
            end
        end
        rr_next = (32'(last_src) == NR_SRC - 1) ? '0 : last_src + SRC_W'(1);
    end

    // A full FIFO only accepts a push when its head leaves in the same cycle
    always_comb begin
        push_acc = '0;
        drop     = '0;
        for (int s = 0; s < NR_SRC; s++) begin
            push_acc[s] = src_valid_i[s] && !flush_i && (!full[s] || pop[s]);
            drop[s]     = src_valid_i[s] && !flush_i && full[s] && !pop[s];
        end
    end

    // Write port payloads, zeroed when no source is granted
    always_comb begin
        wb_valid_o    = grant_valid;
        wb_trans_id_o = '0;
        wb_result_o   = '0;
        wb_ex_o       = '0;
        for (int p = 0; p < NR_WB; p++) begin
            if (grant_valid[p]) begin
                wb_trans_id_o[p] = mem_tid[grant_src[p]][rptr[grant_src[p]]];
                wb_result_o[p]   = mem_res[grant_src[p]][rptr[grant_src[p]]];
                wb_ex_o[p]       = mem_ex[grant_src[p]][rptr[grant_src[p]]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < NR_SRC; s++) begin
                count[s] <= '0;
                rptr[s]  <= '0;
                wptr[s]  <= '0;
            end
            rr         <= '0;
            overflow_o <= 1'b0;
        end else begin
            for (int s = 0; s < NR_SRC; s++) begin
                if (flush_i) begin
                    count[s] <= '0;
                    rptr[s]  <= '0;
                    wptr[s]  <= '0;
                end else begin
                    if (push_acc[s]) begin
                        mem_tid[s][wptr[s]] <= src_trans_id_i[s];
                        mem_res[s][wptr[s]] <= src_result_i[s];
                        mem_ex[s][wptr[s]]  <= src_ex_i[s];
                        wptr[s]             <= wptr[s] + PTR_W'(1);
                    end
                    if (pop[s]) begin
                        rptr[s] <= rptr[s] + PTR_W'(1);
                    end
                    if (push_acc[s] && !pop[s]) begin
                        count[s] <= count[s] + CNT_W'(1);
                    end else if (pop[s] && !push_acc[s]) begin
                        count[s] <= count[s] - CNT_W'(1);
                    end
                end
            end
            // rr holds across a flush even if a handshake completes
            if (any_pop && !flush_i) begin
                rr <= rr_next;
            end
            if (|drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_collector.sv
// Directed self-checking bench for wb_collector with default parameters.
module tb_wb_collector;
    import wb_collector_pkg::exception_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  flush;
    logic [3:0]            src_valid;
    logic [3:0][3:0]       src_tid;
    logic [3:0][63:0]      src_res;
    exception_t [3:0]      src_ex;
    logic [3:0]            almost_full;
    logic [1:0]            wb_valid;
    logic [1:0][3:0]       wb_tid;
    logic [1:0][63:0]      wb_res;
    exception_t [1:0]      wb_ex;
    logic [1:0]            ready;
    logic                  overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_collector dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .src_valid_i       (src_valid),
        .src_trans_id_i    (src_tid),
        .src_result_i      (src_res),
        .src_ex_i          (src_ex),
        .src_almost_full_o (almost_full),
        .wb_valid_o        (wb_valid),
        .wb_trans_id_o     (wb_tid),
        .wb_result_o       (wb_res),
        .wb_ex_o           (wb_ex),
        .wb_ready_i        (ready),
        .overflow_o        (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        src_valid = '0;
        src_tid   = '0;
        src_res   = '0;
        src_ex    = '0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        ready     = 2'b11;
        src_valid = 4'b1111;
        src_tid   = {4'd4, 4'd3, 4'd2, 4'd1};
        src_res   = {64'h4, 64'h3, 64'h2, 64'h1};
        src_ex    = '0;
        tick();
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", wb_valid); end
        checks++; if (wb_tid !== 8'h00) begin errors++; $display("FAIL reset_tid: got %h expected 00", wb_tid); end
        checks++; if (wb_res !== 128'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", wb_res); end
        checks++; if (wb_ex !== '0) begin errors++; $display("FAIL reset_ex: got %h expected 0", wb_ex); end
        checks++; if (almost_full !== 4'b0000) begin errors++; $display("FAIL reset_almost_full: got %b expected 0000", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
        idle();
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL post_reset_valid: got %b expected 00", wb_valid); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL post_reset_valid2: got %b expected 00", wb_valid); end
    endtask

    task automatic test_round_robin();
        exception_t exp_ex;
        exp_ex    = '{cause: 64'd2, tval: 64'h55, valid: 1'b1};
        ready     = 2'b11;
        src_valid = 4'b1111;
        src_tid   = {4'd4, 4'd3, 4'd2, 4'd1};
        src_res   = {64'h103, 64'h102, 64'h101, 64'h100};
        src_ex    = '0;
        src_ex[3] = exp_ex;
        tick();
        idle();
        checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL rr_valid1: got %b expected 11", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd1) begin errors++; $display("FAIL rr_tid1_p0: got %0d expected 1", wb_tid[0]); end
        checks++; if (wb_tid[1] !== 4'd2) begin errors++; $display("FAIL rr_tid1_p1: got %0d expected 2", wb_tid[1]); end
        checks++; if (wb_res[1] !== 64'h101) begin errors++; $display("FAIL rr_res1_p1: got %h expected 101", wb_res[1]); end
        tick();
        checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL rr_valid2: got %b expected 11", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd3) begin errors++; $display("FAIL rr_tid2_p0: got %0d expected 3", wb_tid[0]); end
        checks++; if (wb_tid[1] !== 4'd4) begin errors++; $display("FAIL rr_tid2_p1: got %0d expected 4", wb_tid[1]); end
        checks++; if (wb_ex[1] !== exp_ex) begin errors++; $display("FAIL rr_ex2_p1: got %h expected %h", wb_ex[1], exp_ex); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL rr_drained: got %b expected 00", wb_valid); end
        src_valid  = 4'b0001;
        src_tid[0] = 4'd10;
        tick();
        idle();
        checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL rr_flu_valid: got %b expected 01", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd10) begin errors++; $display("FAIL rr_flu_tid: got %0d expected 10", wb_tid[0]); end
        tick();
    endtask

    task automatic test_latency();
        ready      = 2'b11;
        src_valid  = 4'b0010;
        src_tid[1] = 4'd5;
        src_res[1] = 64'hDEAD_BEEF;
        tick();
        idle();
        checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL lat_valid: got %b expected 01", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd5) begin errors++; $display("FAIL lat_tid: got %0d expected 5", wb_tid[0]); end
        checks++; if (wb_res[0] !== 64'hDEAD_BEEF) begin errors++; $display("FAIL lat_result: got %h expected deadbeef", wb_res[0]); end
        checks++; if (wb_res[1] !== 64'h0) begin errors++; $display("FAIL lat_idle_port: got %h expected 0", wb_res[1]); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL lat_gone: got %b expected 00", wb_valid); end
    endtask

    task automatic test_backpressure();
        ready      = 2'b00;
        src_valid  = 4'b1000;
        src_tid[3] = 4'd7;
        tick();
        checks++; if (almost_full !== 4'b1000) begin errors++; $display("FAIL bp_af1: got %b expected 1000", almost_full); end
        checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL bp_valid1: got %b expected 01", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd7) begin errors++; $display("FAIL bp_tid1: got %0d expected 7", wb_tid[0]); end
        src_tid[3] = 4'd8;
        tick();
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_no_ovf: got %b expected 0", overflow); end
        src_tid[3] = 4'd9;
        tick();
        idle();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf: got %b expected 1", overflow); end
        ready = 2'b11;
        checks++; if (wb_tid[0] !== 4'd7) begin errors++; $display("FAIL bp_head7: got %0d expected 7", wb_tid[0]); end
        tick();
        checks++; if (wb_valid !== 2'b01) begin errors++; $display("FAIL bp_valid8: got %b expected 01", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd8) begin errors++; $display("FAIL bp_head8: got %0d expected 8", wb_tid[0]); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL bp_no9: got %b expected 00", wb_valid); end
        checks++; if (almost_full !== 4'b0000) begin errors++; $display("FAIL bp_af_empty: got %b expected 0000", almost_full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        idle();
        ready = 2'b00;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_reset: got %b expected 0", overflow); end
        src_valid  = 4'b0001;
        src_tid[0] = 4'd1;
        tick();
        src_tid[0] = 4'd2;
        tick();
        checks++; if (almost_full !== 4'b0001) begin errors++; $display("FAIL fpp_af: got %b expected 0001", almost_full); end
        ready      = 2'b01;
        src_tid[0] = 4'd3;
        checks++; if (wb_tid[0] !== 4'd1) begin errors++; $display("FAIL fpp_head1: got %0d expected 1", wb_tid[0]); end
        tick();
        idle();
        checks++; if (wb_tid[0] !== 4'd2) begin errors++; $display("FAIL fpp_head2: got %0d expected 2", wb_tid[0]); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", overflow); end
        tick();
        checks++; if (wb_tid[0] !== 4'd3) begin errors++; $display("FAIL fpp_head3: got %0d expected 3", wb_tid[0]); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL fpp_drained: got %b expected 00", wb_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf_end: got %b expected 0", overflow); end
    endtask

    task automatic test_flush();
        ready     = 2'b00;
        src_valid = 4'b0111;
        src_tid   = {4'd0, 4'd3, 4'd2, 4'd1};
        tick();
        idle();
        checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL fl_pre_valid: got %b expected 11", wb_valid); end
        checks++; if (wb_tid !== {4'd3, 4'd2}) begin errors++; $display("FAIL fl_pre_tid: got %h expected 32", wb_tid); end
        flush      = 1'b1;
        src_valid  = 4'b1000;
        src_tid[3] = 4'd6;
        tick();
        idle();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL fl_valid: got %b expected 00", wb_valid); end
        checks++; if (almost_full !== 4'b0000) begin errors++; $display("FAIL fl_af: got %b expected 0000", almost_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fl_ovf: got %b expected 0", overflow); end
        ready      = 2'b11;
        src_valid  = 4'b0101;
        src_tid[0] = 4'd9;
        src_tid[2] = 4'd11;
        tick();
        idle();
        checks++; if (wb_valid !== 2'b11) begin errors++; $display("FAIL fl_post_valid: got %b expected 11", wb_valid); end
        checks++; if (wb_tid[0] !== 4'd11) begin errors++; $display("FAIL fl_post_p0: got %0d expected 11", wb_tid[0]); end
        checks++; if (wb_tid[1] !== 4'd9) begin errors++; $display("FAIL fl_post_p1: got %0d expected 9", wb_tid[1]); end
        tick();
        checks++; if (wb_valid !== 2'b00) begin errors++; $display("FAIL fl_end: got %b expected 00", wb_valid); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_latency();
        test_backpressure();
        test_full_push_pop();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
